// File: rtl/nvme_track_drain.sv
// nvme_track_drain: round-robin drain of tracker completion status into a completion FIFO
//
// Scans track_status round-robin from rr_ptr, issues one track_update pulse per selected
// action id and waits for track_update_done.  A valid returned info word pushes
// {id, error} into a first-word-fall-through completion FIFO read via cpl_valid/cpl_ready.
// Only one update is ever in flight.  A selection is made only when the FIFO has room,
// which guarantees space for the push.
//
// Ports:
//   axi_aclk, axi_aresetn        clock, asynchronous active-low reset
//   drain_enable, track_init     scan permission and tracker-ready qualifiers
//   track_status                 per-action "head entry complete" bits
//   track_update/_id             one-cycle update pulse, id held until the next selection
//   track_update_done/_data      tracker response; data bit0=valid, bit1=error
//   cpl_valid/ready/id/error     completion FIFO head and pop handshake
//   cpl_count                    FIFO occupancy
//   busy                         FSM not IDLE
//   wdog_error                   sticky: done not returned within WDOG_CYCLES
//
// Optional feature macro TRACK_DRAIN_STATS_EN adds stat_clear, stat_cpl_cnt, stat_err_cnt.
module nvme_track_drain #(
    parameter int ACTION_ID_BITS  = 4,
    parameter int TRACK_INFO_BITS = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int WDOG_CYCLES     = 64
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic                         drain_enable,
    input  logic                         track_init,
    input  logic [2**ACTION_ID_BITS-1:0] track_status,
    output logic                         track_update,
    output logic [ACTION_ID_BITS-1:0]    track_update_id,
    input  logic                         track_update_done,
    input  logic [TRACK_INFO_BITS-1:0]   track_update_data,
    output logic                         cpl_valid,
    input  logic                         cpl_ready,
    output logic [ACTION_ID_BITS-1:0]    cpl_id,
    output logic                         cpl_error,
    output logic [$clog2(FIFO_DEPTH):0]  cpl_count,
    output logic                         busy,
`ifdef TRACK_DRAIN_STATS_EN
    input  logic                         stat_clear,
    output logic [31:0]                  stat_cpl_cnt,
    output logic [31:0]                  stat_err_cnt,
`endif
    output logic                         wdog_error
);
    localparam int NUM_IDS = 2**ACTION_ID_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WD_W    = $clog2(WDOG_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [ACTION_ID_BITS-1:0] id;
        logic                      err;
    } entry_t;

    state_t                    state_q, state_d;
    logic [ACTION_ID_BITS-1:0] id_q, id_d;
    logic [ACTION_ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]           wdog_cnt_q, wdog_cnt_d;
    logic                      wdog_error_q, wdog_error_d;
    logic                      track_update_q, track_update_d;
    logic                      busy_q, busy_d;
    entry_t                    mem_q [FIFO_DEPTH];
    entry_t                    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic                      start;
    logic                      push;
    logic                      pop;
    logic [NUM_IDS-1:0]        upper_req;
    logic [ACTION_ID_BITS-1:0] pick_all, pick_upper, pick_id;
    entry_t                    head;

    // Round-robin pick: lowest requester at or above rr_ptr, else wrap to the lowest overall.
    always_comb begin
        upper_req  = track_status & ({NUM_IDS{1'b1}} << rr_ptr_q);
        pick_all   = '0;
        pick_upper = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (track_status[i]) pick_all = ACTION_ID_BITS'(i);
            if (upper_req[i]) pick_upper = ACTION_ID_BITS'(i);
        end
        pick_id = |upper_req ? pick_upper : pick_all;
    end

    // The room check here is what guarantees the later push never overflows.
    assign start = drain_enable & track_init & ~wdog_error_q
                 & (count_q < CNT_W'(FIFO_DEPTH)) & (|track_status);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        wdog_cnt_d   = wdog_cnt_q;
        wdog_error_d = wdog_error_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    id_d    = pick_id;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wdog_cnt_d = '0;
            end
            WAIT: begin
                // data[0]=0 means the status bit was stale: consume the slot without a push.
                if (track_update_done) begin
                    push     = track_update_data[0];
                    rr_ptr_d = id_q + 1'b1;
                    state_d  = HOLD;
                end else if (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
                    wdog_error_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
            end
            // HOLD gives the tracker one cycle to retire the status bit before reselecting.
            default: state_d = IDLE;
        endcase
        track_update_d = (state_d == ISSUE);
        busy_d         = (state_d != IDLE);
    end

    assign pop = cpl_ready & (count_q != '0);

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{id: id_q, err: track_update_data[1]};
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q        <= IDLE;
            id_q           <= '0;
            rr_ptr_q       <= '0;
            wdog_cnt_q     <= '0;
            wdog_error_q   <= 1'b0;
            track_update_q <= 1'b0;
            busy_q         <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            rr_ptr_q       <= rr_ptr_d;
            wdog_cnt_q     <= wdog_cnt_d;
            wdog_error_q   <= wdog_error_d;
            track_update_q <= track_update_d;
            busy_q         <= busy_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign track_update    = track_update_q;
    assign track_update_id = id_q;
    assign busy            = busy_q;
    assign wdog_error      = wdog_error_q;
    assign cpl_count       = count_q;
    assign cpl_valid       = count_q != '0;
    // Stale slot contents stay hidden while the FIFO is empty.
    assign cpl_id          = cpl_valid ? head.id : '0;
    assign cpl_error       = cpl_valid & head.err;

`ifdef TRACK_DRAIN_STATS_EN
    logic [31:0] stat_cpl_q, stat_cpl_d;
    logic [31:0] stat_err_q, stat_err_d;

    // Saturating counters; a clear in the same cycle as an increment wins.
    always_comb begin
        stat_cpl_d = stat_clear ? '0 : stat_cpl_q + 32'(push & ~&stat_cpl_q);
        stat_err_d = stat_clear ? '0 : stat_err_q + 32'(push & track_update_data[1] & ~&stat_err_q);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stat_cpl_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_cpl_q <= stat_cpl_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_cpl_cnt = stat_cpl_q;
    assign stat_err_cnt = stat_err_q;
`endif
endmodule
